// File: rtl/score_counter.sv
`default_nettype none
// ============================================================================
// Module   : score_counter
// Brief    : Three-digit BCD game score with edge-detected hits, saturation
//            at 999, synchronous game clear and a persistent high score.
// Revision : 1.0 - initial release
// ============================================================================
module score_counter #(
    parameter int POINTS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        add_score,
    input  logic        game_clr,
    output logic [11:0] score_bcd,
    output logic [11:0] high_bcd,
    output logic        score_upd,
    output logic        new_high
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [4:0] PTS = 5'(POINTS);

    state_t      state;
    logic        add_d;
    logic        hit;
    logic [4:0]  ones_sum;
    logic [4:0]  ones_m10;
    logic [4:0]  tens_sum;
    logic [4:0]  tens_m10;
    logic [4:0]  hund_sum;
    logic        carry_ones;
    logic        carry_tens;
    logic [3:0]  ones_nxt;
    logic [3:0]  tens_nxt;
    logic [11:0] score_nxt;

    assign hit = add_score & ~add_d;

    // Ripple BCD add; an overflow out of the hundreds digit saturates to 999.
    always_comb begin
        ones_sum   = {1'b0, score_bcd[3:0]} + PTS;
        ones_m10   = ones_sum - 5'd10;
        carry_ones = (ones_sum > 5'd9);
        ones_nxt   = carry_ones ? ones_m10[3:0] : ones_sum[3:0];

        tens_sum   = {1'b0, score_bcd[7:4]} + {4'b0000, carry_ones};
        tens_m10   = tens_sum - 5'd10;
        carry_tens = (tens_sum > 5'd9);
        tens_nxt   = carry_tens ? tens_m10[3:0] : tens_sum[3:0];

        hund_sum   = {1'b0, score_bcd[11:8]} + {4'b0000, carry_tens};

        if (hund_sum > 5'd9) begin
            score_nxt = 12'h999;
        end else begin
            score_nxt = {hund_sum[3:0], tens_nxt, ones_nxt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            add_d     <= 1'b0;
            score_bcd <= 12'h000;
            high_bcd  <= 12'h000;
            score_upd <= 1'b0;
            new_high  <= 1'b0;
        end else begin
            add_d     <= add_score;
            score_upd <= 1'b0;

            if (game_clr) begin
                state     <= IDLE;
                score_bcd <= 12'h000;
            end else if (hit) begin
                state <= PLAY;
                if (score_nxt != score_bcd) begin
                    score_bcd <= score_nxt;
                    score_upd <= 1'b1;
                end
            end

            // In IDLE the score is zero, so gating on PLAY never hides a new high.
            if ((state == PLAY) && (score_bcd > high_bcd)) begin
                high_bcd <= score_bcd;
                new_high <= 1'b1;
            end else begin
                new_high <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_counter
// Brief    : Directed bench for score_counter (POINTS=1 and POINTS=7 copies)
//            with a decimal-integer reference model and per-cycle compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_counter;

    logic        clk;
    logic        rst_n;
    logic        add_score;
    logic        game_clr;
    logic [11:0] sc [2];
    logic [11:0] hi [2];
    logic        up [2];
    logic        nh [2];

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt = 0;
    int nh_cnt = 0;

    score_counter #(.POINTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .add_score(add_score), .game_clr(game_clr),
        .score_bcd(sc[0]), .high_bcd(hi[0]), .score_upd(up[0]), .new_high(nh[0])
    );

    score_counter #(.POINTS(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .add_score(add_score), .game_clr(game_clr),
        .score_bcd(sc[1]), .high_bcd(hi[1]), .score_upd(up[1]), .new_high(nh[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scores kept as plain decimal integers.
    int m_sc [2];
    int m_hi [2];
    bit m_up [2];
    bit m_nh [2];
    bit m_add;

    function automatic int pts(int k);
        return (k == 0) ? 1 : 7;
    endfunction

    function automatic int sat_add(int s, int p);
        return (s + p > 999) ? 999 : s + p;
    endfunction

    function automatic logic [11:0] to_bcd(int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_add <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_sc[k] <= 0;
                m_hi[k] <= 0;
                m_up[k] <= 1'b0;
                m_nh[k] <= 1'b0;
            end
        end else begin
            m_add <= add_score;
            for (int k = 0; k < 2; k++) begin
                m_hi[k] <= (m_sc[k] > m_hi[k]) ? m_sc[k] : m_hi[k];
                m_nh[k] <= (m_sc[k] > m_hi[k]);
                m_up[k] <= !game_clr && add_score && !m_add
                           && (sat_add(m_sc[k], pts(k)) != m_sc[k]);
                if (game_clr)
                    m_sc[k] <= 0;
                else if (add_score && !m_add)
                    m_sc[k] <= sat_add(m_sc[k], pts(k));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("score[%0d]", k), int'(sc[k]), int'(to_bcd(m_sc[k])));
            chk($sformatf("high[%0d]", k),  int'(hi[k]), int'(to_bcd(m_hi[k])));
            chk($sformatf("upd[%0d]", k),   int'(up[k]), int'(m_up[k]));
            chk($sformatf("nhigh[%0d]", k), int'(nh[k]), int'(m_nh[k]));
        end
        if (up[0]) upd_cnt++;
        if (nh[0]) nh_cnt++;
    end

    task automatic hit();
        @(negedge clk) add_score = 1'b1;
        @(negedge clk) add_score = 1'b0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) hit();
    endtask

    int snap;

    initial begin
        rst_n     = 1'b0;
        add_score = 1'b0;
        game_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_score", int'(sc[0]), 'h000);
        chk("rst_high",  int'(hi[0]), 'h000);
        chk("rst_upd",   int'(up[0]), 0);
        rst_n = 1'b1;

        snap = upd_cnt;
        hits(3);
        @(negedge clk);
        chk("three_hits_p1", int'(sc[0]), 'h003);
        chk("three_hits_p7", int'(sc[1]), 'h021);
        chk("three_upd",     upd_cnt - snap, 3);
        chk("three_high",    int'(hi[0]), 'h003);

        snap = upd_cnt;
        @(negedge clk) add_score = 1'b1;
        repeat (20) @(negedge clk);
        add_score = 1'b0;
        @(negedge clk);
        chk("hold_score", int'(sc[0]), 'h004);
        chk("hold_upd",   upd_cnt - snap, 1);

        hits(5);
        chk("score_009", int'(sc[0]), 'h009);
        hit();
        chk("score_010", int'(sc[0]), 'h010);
        hits(89);
        chk("score_099", int'(sc[0]), 'h099);
        hit();
        chk("score_100", int'(sc[0]), 'h100);
        chk("p7_700",    int'(sc[1]), 'h700);
        hits(899);
        chk("score_999", int'(sc[0]), 'h999);
        chk("p7_sat",    int'(sc[1]), 'h999);
        @(negedge clk);
        snap = upd_cnt;
        hit();
        @(negedge clk);
        chk("sat_score", int'(sc[0]), 'h999);
        chk("sat_noupd", upd_cnt - snap, 0);

        // Reset lands mid-cycle while a rising hit is pending, held through release.
        @(negedge clk) add_score = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_score", int'(sc[0]), 'h000);
        chk("mid_rst_high",  int'(hi[0]), 'h000);
        chk("mid_rst_upd",   int'(up[0]), 0);
        chk("mid_rst_nh",    int'(nh[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_score_p1", int'(sc[0]), 'h001);
        chk("rel_score_p7", int'(sc[1]), 'h007);
        add_score = 1'b0;

        hits(41);
        @(negedge clk);
        chk("score_042", int'(sc[0]), 'h042);
        chk("high_042",  int'(hi[0]), 'h042);

        @(negedge clk);
        add_score = 1'b1;
        game_clr  = 1'b1;
        @(negedge clk);
        chk("clr_score", int'(sc[0]), 'h000);
        chk("clr_upd",   int'(up[0]), 0);
        chk("clr_high",  int'(hi[0]), 'h042);
        game_clr = 1'b0;
        @(negedge clk);
        add_score = 1'b0;
        @(negedge clk);
        chk("post_clr_level", int'(sc[0]), 'h000);

        snap = nh_cnt;
        hits(43);
        repeat (2) @(negedge clk);
        chk("climb_score", int'(sc[0]), 'h043);
        chk("climb_high",  int'(hi[0]), 'h043);
        chk("climb_nh",    nh_cnt - snap, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
